// File: rtl/reg_file_sb_pkg.sv
// rtl/reg_file_sb_pkg.sv - shared types and default sizes for the scoreboarded register file
package reg_file_sb_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/reg_file_sb_rdport.sv
// rtl/reg_file_sb_rdport.sv - one combinational read port: array mux, zero register, write bypass, valid
module reg_file_sb_rdport
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = 1 << ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] mem,
  input  logic [DEPTH-1:0]             pend,
  input  logic                         busy,
  input  logic                         wr_acc,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_valid
);

  // Zero register outranks bypass: a write to r0 is never accepted when it is hardwired.
  always_comb begin
    rd_data  = mem[rd_addr];
    rd_valid = !busy && !pend[rd_addr];
    if (ZERO_REG != 0 && rd_addr == '0) begin
      rd_data  = '0;
      rd_valid = !busy;
    end else if (BYPASS != 0 && wr_acc && rd_addr == wr_addr) begin
      rd_data  = wr_data;
      rd_valid = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - DEPTHxDATA_W register file with pending scoreboard and zeroing sweep engine
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLEAR,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic [DATA_W-1:0] IN,
  input  logic              RESERVE,
  input  logic [ADDR_W-1:0] RESADDRESS,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              OUT1_VALID,
  output logic              OUT2_VALID,
  output logic              BUSY
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t                      state, state_nxt;
  logic [ADDR_W-1:0]           ptr, ptr_nxt;
  logic [DEPTH-1:0]            pend, pend_nxt;
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic                        busy, wr_acc, res_acc;

  assign busy    = (state == SWEEP);
  assign BUSY    = busy;
  assign wr_acc  = WRITE   && !busy && !(ZERO_REG != 0 && INADDRESS  == '0);
  assign res_acc = RESERVE && !busy && !(ZERO_REG != 0 && RESADDRESS == '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= SWEEP;
      ptr   <= '0;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      pend  <= pend_nxt;
    end
  end

  // Reserve is applied after the write clear so a same-address pair leaves the register pending.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    pend_nxt  = pend;
    case (state)
      SWEEP: begin
        ptr_nxt = ptr + ADDR_W'(1);
        if (ptr == ADDR_W'(DEPTH - 1)) state_nxt = IDLE;
      end
      IDLE: begin
        if (wr_acc)  pend_nxt[INADDRESS]  = 1'b0;
        if (res_acc) pend_nxt[RESADDRESS] = 1'b1;
        if (CLEAR) begin
          state_nxt = SWEEP;
          ptr_nxt   = '0;
          pend_nxt  = '0;
        end
      end
      default: state_nxt = SWEEP;
    endcase
  end

  // Storage has no reset; the sweep is what gives it a defined value.
  always_ff @(posedge CLK) begin
    if (busy)        mem[ptr]       <= '0;
    else if (wr_acc) mem[INADDRESS] <= IN;
  end

  reg_file_sb_rdport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_rd1 (
    .mem(mem), .pend(pend), .busy(busy), .wr_acc(wr_acc), .wr_addr(INADDRESS),
    .wr_data(IN), .rd_addr(OUT1ADDRESS), .rd_data(OUT1), .rd_valid(OUT1_VALID)
  );

  reg_file_sb_rdport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_rd2 (
    .mem(mem), .pend(pend), .busy(busy), .wr_acc(wr_acc), .wr_addr(INADDRESS),
    .wr_data(IN), .rd_addr(OUT2ADDRESS), .rd_data(OUT2), .rd_valid(OUT2_VALID)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed bench for reg_file_sb in bypass, no-bypass and zero-register builds
module tb_reg_file_sb;

  logic       CLK = 1'b0;
  logic       RESET, CLEAR, WRITE, RESERVE;
  logic [2:0] INADDRESS, RESADDRESS, OUT1ADDRESS, OUT2ADDRESS;
  logic [7:0] IN;

  logic [7:0] a_out1, a_out2, b_out1, b_out2, z_out1, z_out2;
  logic       a_v1, a_v2, a_busy, b_v1, b_v2, b_busy, z_v1, z_v2, z_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  reg_file_sb #(.BYPASS(1), .ZERO_REG(0)) dut_a (
    .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(a_out1), .OUT2(a_out2), .OUT1_VALID(a_v1), .OUT2_VALID(a_v2), .BUSY(a_busy)
  );

  reg_file_sb #(.BYPASS(0), .ZERO_REG(0)) dut_b (
    .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(b_out1), .OUT2(b_out2), .OUT1_VALID(b_v1), .OUT2_VALID(b_v2), .BUSY(b_busy)
  );

  reg_file_sb #(.BYPASS(1), .ZERO_REG(1)) dut_z (
    .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(z_out1), .OUT2(z_out2), .OUT1_VALID(z_v1), .OUT2_VALID(z_v2), .BUSY(z_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b0; CLEAR = 1'b0; WRITE = 1'b0; RESERVE = 1'b0;
    INADDRESS = '0; RESADDRESS = '0; OUT1ADDRESS = '0; OUT2ADDRESS = '0; IN = '0;
    tick(); tick();
    check("rst_busy", 32'(a_busy), 1);
    check("rst_valid1", 32'(a_v1), 0);
    check("rst_valid2", 32'(a_v2), 0);

    // Release reset away from the edge; BUSY must fall on the 8th edge.
    RESET = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("rel_busy_%0d", i), 32'(a_busy), (i < 8) ? 1 : 0);
    end
    check("rel_busy_z", 32'(z_busy), 0);
    for (int a = 0; a < 8; a++) begin
      OUT1ADDRESS = 3'(a); OUT2ADDRESS = 3'(7 - a);
      #1;
      check($sformatf("init_out1_r%0d", a), 32'(a_out1), 0);
      check($sformatf("init_v1_r%0d", a), 32'(a_v1), 1);
      check($sformatf("init_out2_r%0d", 7 - a), 32'(a_out2), 0);
    end

    // Write with bypass vs without.
    tick();
    OUT1ADDRESS = 3'd5; WRITE = 1'b1; INADDRESS = 3'd5; IN = 8'hA7;
    #2;
    check("byp_a_out", 32'(a_out1), 'hA7);
    check("byp_a_valid", 32'(a_v1), 1);
    check("nobyp_b_out", 32'(b_out1), 'h00);
    tick();
    WRITE = 1'b0;
    #2;
    check("after_b_out", 32'(b_out1), 'hA7);
    check("after_a_out", 32'(a_out1), 'hA7);

    // Reserve r3 then satisfy it with a write.
    tick();
    RESERVE = 1'b1; RESADDRESS = 3'd3; OUT1ADDRESS = 3'd3;
    #2;
    check("res_same_cycle_v", 32'(a_v1), 1);
    tick();
    RESERVE = 1'b0;
    #2;
    check("res_a_v", 32'(a_v1), 0);
    check("res_b_v", 32'(b_v1), 0);
    WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h42;
    #2;
    check("fill_byp_out", 32'(a_out1), 'h42);
    check("fill_byp_v", 32'(a_v1), 1);
    check("fill_nobyp_v", 32'(b_v1), 0);
    tick();
    WRITE = 1'b0;
    #2;
    check("fill_a_v", 32'(a_v1), 1);
    check("fill_b_v", 32'(b_v1), 1);
    check("fill_b_out", 32'(b_out1), 'h42);
    tick();
    check("fill_a_v_hold", 32'(a_v1), 1);

    // Same-cycle write + reserve: data lands, reserve wins.
    WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h42; RESERVE = 1'b1; RESADDRESS = 3'd3;
    #2;
    check("wr_res_byp_v", 32'(a_v1), 1);
    tick();
    WRITE = 1'b0; RESERVE = 1'b0;
    #2;
    check("wr_res_out", 32'(a_out1), 'h42);
    check("wr_res_v", 32'(a_v1), 0);
    check("wr_res_b_out", 32'(b_out1), 'h42);

    // Register 0 with and without hardwired zero.
    tick();
    WRITE = 1'b1; INADDRESS = 3'd0; IN = 8'hFF; RESERVE = 1'b1; RESADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
    #2;
    check("z0_cyc_out", 32'(z_out2), 0);
    check("z0_cyc_v", 32'(z_v2), 1);
    check("a0_cyc_out", 32'(a_out2), 'hFF);
    tick();
    WRITE = 1'b0; RESERVE = 1'b0;
    #2;
    check("z0_out", 32'(z_out2), 0);
    check("z0_v", 32'(z_v2), 1);
    check("a0_out", 32'(a_out2), 'hFF);
    check("a0_v", 32'(a_v2), 0);

    // Fill every register, then CLEAR.
    for (int a = 0; a < 8; a++) begin
      tick();
      WRITE = 1'b1; INADDRESS = 3'(a); IN = 8'(16 + a);
    end
    tick();
    WRITE = 1'b0; OUT1ADDRESS = 3'd6; OUT2ADDRESS = 3'd0;
    #2;
    check("fill_r6", 32'(a_out1), 'h16);
    check("fill_r0_v", 32'(a_v2), 1);
    CLEAR = 1'b1;
    #2;
    check("clr_busy_pre", 32'(a_busy), 0);
    tick();
    CLEAR = 1'b0;
    check("clr_busy_1", 32'(a_busy), 1);
    for (int i = 2; i <= 9; i++) begin
      if (i == 3) begin
        WRITE = 1'b1; INADDRESS = 3'd0; IN = 8'h55;
      end
      tick();
      WRITE = 1'b0;
      check($sformatf("clr_busy_%0d", i), 32'(a_busy), (i < 9) ? 1 : 0);
    end
    for (int a = 0; a < 8; a++) begin
      OUT1ADDRESS = 3'(a);
      #1;
      check($sformatf("clr_out_r%0d", a), 32'(a_out1), 0);
      check($sformatf("clr_v_r%0d", a), 32'(a_v1), 1);
    end

    // Reset in the middle of a sweep (ptr == 4).
    tick();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    RESET = 1'b0;
    #1;
    check("mid_rst_busy", 32'(a_busy), 1);
    check("mid_rst_v", 32'(a_v1), 0);
    tick(); tick();
    RESET = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("mid_rel_busy_%0d", i), 32'(a_busy), (i < 8) ? 1 : 0);
    end

    // Reset drops a pending reservation.
    RESERVE = 1'b1; RESADDRESS = 3'd2; OUT1ADDRESS = 3'd2;
    tick();
    RESERVE = 1'b0;
    #1;
    check("pre_rst_pend_v", 32'(a_v1), 0);
    RESET = 1'b0;
    #2;
    RESET = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("post_rst_busy", 32'(a_busy), 0);
    check("post_rst_pend_v", 32'(a_v1), 1);
    check("post_rst_out", 32'(a_out1), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
